pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//   Control FSM that sequences the 32-bit program counter register through boot, fetch, issue, retire and trap.
//   Drives the register's next-value input every cycle and reads back its current PC and registered fault flag.
//   Talks to instruction memory over a req/ack handshake and hands the fetched word to decode over valid/ready.
//   Takes the retire/redirect event from execute, computes the next PC and vectors to a trap handler on faults.
// PARAMETERS
//   RESET_VECTOR  32'h0000_0000  first PC loaded after reset; bits [1:0] forced to 0
//   TRAP_VECTOR   32'h0000_0010  PC loaded on any trap; bits [1:0] forced to 0
// PORTS
//   clk              input   1   clock; all state updates on posedge
//   reset            input   1   synchronous, active-high reset
//   pc_cur           input   32  current PC from program counter register
//   pc_fault         input   1   registered misalignment flag for pc_cur (pc_cur[1]|pc_cur[0])
//   pc_next          output  32  next-value input of program counter register, latched every clk
//   fetch_req        output  1   instruction fetch request
//   fetch_addr       output  32  fetch address (= pc_cur while fetch_req)
//   fetch_ack        input   1   fetch complete; fetch_rdata/fetch_err valid this cycle
//   fetch_rdata      input   32  fetched instruction word
//   fetch_err        input   1   bus error on fetch (qualified by fetch_ack)
//   instr_valid      output  1   instr/instr_pc valid to decode
//   instr_ready      input   1   decode accepts instr
//   instr            output  32  latched instruction word
//   instr_pc         output  32  PC of instr
//   retire_valid     input   1   execute finished current instruction (1-cycle pulse)
//   retire_redirect  input   1   taken branch/jump; qualified by retire_valid
//   retire_target    input   32  redirect target; qualified by retire_redirect
//   trap_valid       output  1   1-cycle pulse when trap taken
//   trap_cause       output  2   0 = PC misaligned, 1 = fetch bus error
//   trap_epc         output  32  faulting PC, held until next trap
//   retired_count    output  32  instructions retired since reset, wraps 32'hFFFF_FFFF -> 0
// BEHAVIOUR
//   States: BOOT, CHECK, FETCH, ISSUE, EXEC, TRAP.
//   Reset: state = BOOT; instr, instr_pc, trap_epc, trap_cause, retired_count = 0; all strobes/valids = 0.
//     Reset mid-operation aborts any fetch/issue; fetch_req and instr_valid are 0 the cycle after reset.
//   pc_next is combinational: RESET_VECTOR in BOOT; TRAP_VECTOR in TRAP; on retire in EXEC, retire_target if
//     redirect else pc_cur+32'd4 (mod 2^32, 32'hFFFF_FFFC+4 -> 0); otherwise pc_cur (hold).
//   BOOT  -> CHECK unconditionally (one cycle).
//   CHECK: pc_cur/pc_fault are now valid for the newly loaded PC. pc_fault=1 -> TRAP (cause 0), else -> FETCH.
//   FETCH: fetch_req=1, fetch_addr=pc_cur; held stable until fetch_ack.
//     On ack, fetch_err=1 -> TRAP (cause 1); else instr<=fetch_rdata, instr_pc<=pc_cur, -> ISSUE.
//     fetch_rdata is ignored when fetch_err=1; fetch_ack outside FETCH is ignored.
//   ISSUE: instr_valid=1, instr/instr_pc stable; instr_valid&instr_ready -> EXEC (one transfer per fetch).
//   EXEC : wait retire_valid; on it load pc_next as above, retired_count++, -> CHECK.
//     retire_valid outside EXEC is ignored and is not counted.
//   TRAP : trap_valid=1 for exactly this cycle; trap_epc<=pc_cur; trap_cause per entry reason; -> CHECK.
//     TRAP_VECTOR is aligned, so a second back-to-back misalignment trap cannot occur.
//   A misaligned retire_target is loaded as-is; CHECK then traps with trap_epc = that target.
//   Minimum loop (ack and ready asserted at first opportunity): CHECK,FETCH,ISSUE,EXEC,retire = 4 cycles/instr.
// TESTING
//   1 reset 2 cyc, ack next cycle, ready=1, retire 1 cyc after issue -> fetch_addr 0,4,8; retired_count=3 after 3 retires
//   2 in EXEC retire_redirect=1, target=32'h100 -> next fetch_addr=32'h100; instr_pc=32'h100 on issue
//   3 redirect target=32'h102 -> trap_valid pulse, cause=0, epc=32'h102; next fetch_addr=32'h10
//   4 fetch_ack with fetch_err=1 at pc 32'h8 -> trap cause=1, epc=32'h8, no instr_valid; then fetch at 32'h10
//   5 instr_ready held 0 for 5 cycles -> instr_valid, instr, instr_pc stable; no retire counted; fetch_req=0
//   6 reset asserted in FETCH with fetch_req=1 -> fetch_req=0 next cycle, retired_count=0, reboot to RESET_VECTOR

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: control FSM that walks the external program counter register
// through boot, PC check, instruction fetch, issue to decode, execute/retire
// and trap entry. The PC register lives outside this block; this block drives
// its next-value input every cycle and reads back the current PC and fault flag.
module pc_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0010
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] i_pc_cur,
   input  logic        i_pc_fault,
   output logic [31:0] o_pc_next,
   output logic        o_fetch_req,
   output logic [31:0] o_fetch_addr,
   input  logic        i_fetch_ack,
   input  logic [31:0] i_fetch_rdata,
   input  logic        i_fetch_err,
   output logic        o_instr_valid,
   input  logic        i_instr_ready,
   output logic [31:0] o_instr,
   output logic [31:0] o_instr_pc,
   input  logic        i_retire_valid,
   input  logic        i_retire_redirect,
   input  logic [31:0] i_retire_target,
   output logic        o_trap_valid,
   output logic [1:0]  o_trap_cause,
   output logic [31:0] o_trap_epc,
   output logic [31:0] o_retired_count
);

   // Vectors are word aligned regardless of how the parameters are set, so a
   // trap can never land on a misaligned handler address.
   localparam logic [31:0] LP_RESET_PC = {RESET_VECTOR[31:2], 2'b00};
   localparam logic [31:0] LP_TRAP_PC  = {TRAP_VECTOR[31:2], 2'b00};

   localparam logic [1:0] LP_CAUSE_MISALIGN = 2'd0;
   localparam logic [1:0] LP_CAUSE_BUSERR   = 2'd1;

   typedef enum logic [2:0] {
      S_BOOT  = 3'd0,
      S_CHECK = 3'd1,
      S_FETCH = 3'd2,
      S_ISSUE = 3'd3,
      S_EXEC  = 3'd4,
      S_TRAP  = 3'd5
   } state_t;

   state_t      r_state;
   state_t      w_state_next;

   logic        w_trap_enter;
   logic [1:0]  w_trap_cause_next;
   logic        w_load_instr;
   logic        w_retire;
   logic [31:0] w_pc_next;

   logic        r_fetch_req;
   logic        r_instr_valid;
   logic        r_trap_valid;
   logic [1:0]  r_trap_cause;
   logic [31:0] r_trap_epc;
   logic [31:0] r_instr;
   logic [31:0] r_instr_pc;
   logic [31:0] r_retired_count;

   // State register; reset aborts whatever fetch or issue is in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_BOOT;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state decode plus the one-cycle events (trap entry, instruction
   // capture, retire) that the register processes below act on.
   always_comb begin
      w_state_next      = r_state;
      w_trap_enter      = 1'b0;
      w_trap_cause_next = LP_CAUSE_MISALIGN;
      w_load_instr      = 1'b0;
      w_retire          = 1'b0;
      case (r_state)
         S_BOOT: begin
            w_state_next = S_CHECK;
         end
         S_CHECK: begin
            // pc_cur/pc_fault now reflect the PC loaded on the previous edge.
            if (i_pc_fault) begin
               w_state_next      = S_TRAP;
               w_trap_enter      = 1'b1;
               w_trap_cause_next = LP_CAUSE_MISALIGN;
            end else begin
               w_state_next = S_FETCH;
            end
         end
         S_FETCH: begin
            if (i_fetch_ack) begin
               if (i_fetch_err) begin
                  w_state_next      = S_TRAP;
                  w_trap_enter      = 1'b1;
                  w_trap_cause_next = LP_CAUSE_BUSERR;
               end else begin
                  w_state_next = S_ISSUE;
                  w_load_instr = 1'b1;
               end
            end else begin
               w_state_next = S_FETCH;
            end
         end
         S_ISSUE: begin
            if (i_instr_ready) begin
               w_state_next = S_EXEC;
            end else begin
               w_state_next = S_ISSUE;
            end
         end
         S_EXEC: begin
            if (i_retire_valid) begin
               w_state_next = S_CHECK;
               w_retire     = 1'b1;
            end else begin
               w_state_next = S_EXEC;
            end
         end
         S_TRAP: begin
            w_state_next = S_CHECK;
         end
         default: begin
            w_state_next = S_BOOT;
         end
      endcase
   end

   // Next PC presented to the PC register; it holds its value unless this
   // block is booting, trapping or retiring an instruction.
   always_comb begin
      w_pc_next = i_pc_cur;
      case (r_state)
         S_BOOT: begin
            w_pc_next = LP_RESET_PC;
         end
         S_TRAP: begin
            w_pc_next = LP_TRAP_PC;
         end
         S_EXEC: begin
            if (i_retire_valid) begin
               if (i_retire_redirect) begin
                  // Misaligned targets are loaded as-is; CHECK traps on them.
                  w_pc_next = i_retire_target;
               end else begin
                  w_pc_next = i_pc_cur + 32'd4;
               end
            end else begin
               w_pc_next = i_pc_cur;
            end
         end
         default: begin
            w_pc_next = i_pc_cur;
         end
      endcase
   end

   // Handshake strobes registered from the next state so they line up with
   // the state they belong to and are clean out of reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_fetch_req   <= 1'b0;
         r_instr_valid <= 1'b0;
         r_trap_valid  <= 1'b0;
      end else begin
         r_fetch_req   <= (w_state_next == S_FETCH);
         r_instr_valid <= (w_state_next == S_ISSUE);
         r_trap_valid  <= w_trap_enter;
      end
   end

   // Capture the fetched word and its PC on a good fetch acknowledge.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_instr    <= 32'd0;
         r_instr_pc <= 32'd0;
      end else if (w_load_instr) begin
         r_instr    <= i_fetch_rdata;
         r_instr_pc <= i_pc_cur;
      end else begin
         r_instr    <= r_instr;
         r_instr_pc <= r_instr_pc;
      end
   end

   // Record the faulting PC and reason on trap entry; held until the next trap.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_trap_epc   <= 32'd0;
         r_trap_cause <= 2'd0;
      end else if (w_trap_enter) begin
         r_trap_epc   <= i_pc_cur;
         r_trap_cause <= w_trap_cause_next;
      end else begin
         r_trap_epc   <= r_trap_epc;
         r_trap_cause <= r_trap_cause;
      end
   end

   // Count retirements taken in EXEC only; wraps naturally at 2^32.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_retired_count <= 32'd0;
      end else if (w_retire) begin
         r_retired_count <= r_retired_count + 32'd1;
      end else begin
         r_retired_count <= r_retired_count;
      end
   end

   assign o_pc_next       = w_pc_next;
   assign o_fetch_req     = r_fetch_req;
   assign o_fetch_addr    = r_fetch_req ? i_pc_cur : 32'd0;
   assign o_instr_valid   = r_instr_valid;
   assign o_instr         = r_instr;
   assign o_instr_pc      = r_instr_pc;
   assign o_trap_valid    = r_trap_valid;
   assign o_trap_cause    = r_trap_cause;
   assign o_trap_epc      = r_trap_epc;
   assign o_retired_count = r_retired_count;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: models the external PC register, a memory
// responder, decode and execute, with scoreboard queues for fetch addresses,
// issued instructions and traps.
module tb_pc_sequencer;

   localparam logic [31:0] RST_VEC  = 32'h0000_0000;
   localparam logic [31:0] TRAP_VEC = 32'h0000_0010;

   logic        clk;
   logic        reset;
   logic [31:0] i_pc_cur;
   logic        i_pc_fault;
   logic [31:0] o_pc_next;
   logic        o_fetch_req;
   logic [31:0] o_fetch_addr;
   logic        i_fetch_ack;
   logic [31:0] i_fetch_rdata;
   logic        i_fetch_err;
   logic        o_instr_valid;
   logic        i_instr_ready;
   logic [31:0] o_instr;
   logic [31:0] o_instr_pc;
   logic        i_retire_valid;
   logic        i_retire_redirect;
   logic [31:0] i_retire_target;
   logic        o_trap_valid;
   logic [1:0]  o_trap_cause;
   logic [31:0] o_trap_epc;
   logic [31:0] o_retired_count;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int exp_count = 0;
   logic [31:0] model_pc = 32'd0;
   logic mon_en = 1'b0;
   logic prev_fetch_req = 1'b0;
   logic prev_trap_valid = 1'b0;

   logic [31:0] q_fetch[$];
   logic [63:0] q_issue[$];
   logic [33:0] q_trap[$];

   pc_sequencer #(.RESET_VECTOR(RST_VEC), .TRAP_VECTOR(TRAP_VEC)) dut (
      .clk(clk), .reset(reset),
      .i_pc_cur(i_pc_cur), .i_pc_fault(i_pc_fault), .o_pc_next(o_pc_next),
      .o_fetch_req(o_fetch_req), .o_fetch_addr(o_fetch_addr),
      .i_fetch_ack(i_fetch_ack), .i_fetch_rdata(i_fetch_rdata), .i_fetch_err(i_fetch_err),
      .o_instr_valid(o_instr_valid), .i_instr_ready(i_instr_ready),
      .o_instr(o_instr), .o_instr_pc(o_instr_pc),
      .i_retire_valid(i_retire_valid), .i_retire_redirect(i_retire_redirect),
      .i_retire_target(i_retire_target),
      .o_trap_valid(o_trap_valid), .o_trap_cause(o_trap_cause), .o_trap_epc(o_trap_epc),
      .o_retired_count(o_retired_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External PC register with its registered misalignment flag.
   initial begin
      i_pc_cur   = 32'd0;
      i_pc_fault = 1'b0;
   end
   always @(posedge clk) begin
      i_pc_cur   <= o_pc_next;
      i_pc_fault <= o_pc_next[1] | o_pc_next[0];
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (mon_en) begin
         check_eq("retired_count", 64'(o_retired_count), 64'(exp_count));
         if (o_fetch_req && !prev_fetch_req) begin
            if (q_fetch.size() == 0) begin
               check_eq("fetch_unexpected", 64'(q_fetch.size()), 64'd1);
            end else begin
               check_eq("fetch_addr", 64'(o_fetch_addr), 64'(q_fetch[0]));
               void'(q_fetch.pop_front());
            end
         end
         if (o_instr_valid && i_instr_ready) begin
            if (q_issue.size() == 0) begin
               check_eq("issue_unexpected", 64'(q_issue.size()), 64'd1);
            end else begin
               check_eq("issue_instr_pc", {o_instr, o_instr_pc}, q_issue[0]);
               void'(q_issue.pop_front());
            end
         end
         if (o_trap_valid) begin
            if (prev_trap_valid) begin
               check_eq("trap_pulse_len", 64'(prev_trap_valid), 64'd0);
            end
            if (q_trap.size() == 0) begin
               check_eq("trap_unexpected", 64'(q_trap.size()), 64'd1);
            end else begin
               check_eq("trap_cause_epc", 64'({o_trap_cause, o_trap_epc}), 64'(q_trap[0]));
               void'(q_trap.pop_front());
            end
         end
      end
      prev_fetch_req  <= o_fetch_req;
      prev_trap_valid <= o_trap_valid;
   end

   // Serve one instruction: memory ack after ack_dly cycles (optionally with
   // a bus error), decode stalls rdy_dly cycles, execute retires immediately.
   task automatic serve(input int ack_dly, input logic err, input int rdy_dly,
                        input logic redir, input logic [31:0] tgt,
                        input logic [31:0] word, output int t_start);
      int n;
      logic [31:0] pc_at;
      logic [31:0] nxt;
      n = 0;
      while (!o_fetch_req && n < 20) begin
         tick();
         n++;
      end
      t_start = cyc;
      check_eq("fetch_wait", 64'(o_fetch_req), 64'd1);
      if (!o_fetch_req) return;
      pc_at = model_pc;
      for (int i = 0; i < ack_dly; i++) begin
         tick();
         check_eq("fetch_req_hold", 64'(o_fetch_req), 64'd1);
         check_eq("fetch_addr_hold", 64'(o_fetch_addr), 64'(pc_at));
      end
      i_fetch_ack   = 1'b1;
      i_fetch_err   = err;
      i_fetch_rdata = err ? 32'hDEAD_BEEF : word;
      if (err) begin
         q_trap.push_back({2'd1, pc_at});
         model_pc = TRAP_VEC;
         q_fetch.push_back(model_pc);
      end else begin
         q_issue.push_back({word, pc_at});
      end
      tick();
      i_fetch_ack = 1'b0;
      i_fetch_err = 1'b0;
      if (err) begin
         check_eq("no_issue_on_err", 64'(o_instr_valid), 64'd0);
         return;
      end
      for (int i = 0; i < rdy_dly; i++) begin
         // Stray retire and ack while stalled in issue must be ignored.
         i_retire_valid    = (i == 0);
         i_retire_redirect = (i == 0);
         i_retire_target   = 32'h0000_0200;
         i_fetch_ack       = (i == 0);
         i_fetch_rdata     = ~word;
         tick();
         check_eq("ivalid_hold", 64'(o_instr_valid), 64'd1);
         check_eq("instr_hold", 64'(o_instr), 64'(word));
         check_eq("instr_pc_hold", 64'(o_instr_pc), 64'(pc_at));
         check_eq("fetch_req_idle", 64'(o_fetch_req), 64'd0);
      end
      i_retire_valid    = 1'b0;
      i_retire_redirect = 1'b0;
      i_fetch_ack       = 1'b0;
      i_instr_ready     = 1'b1;
      tick();
      i_instr_ready = 1'b0;
      check_eq("ivalid_drop", 64'(o_instr_valid), 64'd0);
      nxt = redir ? tgt : pc_at + 32'd4;
      if (nxt[1:0] != 2'b00) begin
         q_trap.push_back({2'd0, nxt});
         model_pc = TRAP_VEC;
      end else begin
         model_pc = nxt;
      end
      q_fetch.push_back(model_pc);
      i_retire_valid    = 1'b1;
      i_retire_redirect = redir;
      i_retire_target   = tgt;
      tick();
      i_retire_valid    = 1'b0;
      i_retire_redirect = 1'b0;
      exp_count++;
   endtask

   initial begin
      int t0, t1, t2, n;
      reset = 1'b1;
      i_fetch_ack = 1'b0; i_fetch_rdata = 32'd0; i_fetch_err = 1'b0;
      i_instr_ready = 1'b0;
      i_retire_valid = 1'b0; i_retire_redirect = 1'b0; i_retire_target = 32'd0;
      tick();
      tick();
      check_eq("rst_fetch_req", 64'(o_fetch_req), 64'd0);
      check_eq("rst_instr_valid", 64'(o_instr_valid), 64'd0);
      check_eq("rst_trap_valid", 64'(o_trap_valid), 64'd0);
      check_eq("rst_count", 64'(o_retired_count), 64'd0);
      check_eq("rst_instr", {o_instr, o_instr_pc}, 64'd0);
      check_eq("rst_trap_regs", 64'({o_trap_cause, o_trap_epc}), 64'd0);
      model_pc = RST_VEC;
      q_fetch.push_back(model_pc);
      mon_en = 1'b1;
      reset  = 1'b0;

      // Sequential fetch 0,4,8 at minimum loop rate.
      serve(0, 1'b0, 0, 1'b0, 32'd0, 32'h1111_0000, t0);
      serve(0, 1'b0, 0, 1'b0, 32'd0, 32'h1111_0004, t1);
      serve(0, 1'b0, 0, 1'b0, 32'd0, 32'h1111_0008, t2);
      check_eq("loop_cycles_a", 64'(t1 - t0), 64'd4);
      check_eq("loop_cycles_b", 64'(t2 - t1), 64'd4);
      check_eq("count_after3", 64'(o_retired_count), 64'd3);

      // Redirect to 0x100, then a misaligned redirect to 0x102 traps.
      serve(0, 1'b0, 0, 1'b1, 32'h0000_0100, 32'h2222_000C, t0);
      serve(0, 1'b0, 0, 1'b1, 32'h0000_0102, 32'h2222_0100, t0);

      // Decode stalls five cycles at the trap handler, then jump to 0x8.
      serve(0, 1'b0, 5, 1'b1, 32'h0000_0008, 32'h3333_0010, t0);
      check_eq("epc_held", 64'(o_trap_epc), 64'h102);

      // Bus error at 0x8 traps with cause 1.
      serve(0, 1'b1, 0, 1'b0, 32'd0, 32'h4444_0008, t0);

      // Slow memory at 0x10, then wrap from 0xFFFF_FFFC to 0.
      serve(3, 1'b0, 0, 1'b1, 32'hFFFF_FFFC, 32'h5555_0010, t0);
      serve(0, 1'b0, 0, 1'b0, 32'd0, 32'h6666_FFFC, t0);
      serve(0, 1'b0, 0, 1'b0, 32'd0, 32'h7777_0000, t0);

      // Reset while fetching at 0x4.
      n = 0;
      while (!o_fetch_req && n < 20) begin
         tick();
         n++;
      end
      check_eq("pre_reset_fetch", 64'(o_fetch_req), 64'd1);
      reset = 1'b1;
      tick();
      check_eq("mid_rst_fetch_req", 64'(o_fetch_req), 64'd0);
      check_eq("mid_rst_instr_valid", 64'(o_instr_valid), 64'd0);
      check_eq("mid_rst_count", 64'(o_retired_count), 64'd0);
      q_fetch.delete();
      q_issue.delete();
      q_trap.delete();
      exp_count = 0;
      model_pc  = RST_VEC;
      q_fetch.push_back(model_pc);
      reset = 1'b0;
      serve(0, 1'b0, 0, 1'b0, 32'd0, 32'h8888_0000, t0);
      check_eq("count_after_reboot", 64'(o_retired_count), 64'd1);

      repeat (4) tick();
      check_eq("q_fetch_left", 64'(q_fetch.size()), 64'd0);
      check_eq("q_issue_left", 64'(q_issue.size()), 64'd0);
      check_eq("q_trap_left", 64'(q_trap.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #50000;
      $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

endmodule
